// File: rtl/riscv_mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mc_control_unit
// Brief    : Multicycle RV32I control FSM. Decodes the instruction register
//            fields and sequences every datapath enable and mux select.
//            Optional macro RISCV_CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap
//            into a sticky ILLEGAL state and raise illegal_instr; without it
//            unknown opcodes retire as a NOP from DECODE.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mc_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       instr_retired
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_instr
`endif
);

    localparam logic [6:0] C_OP_R   = 7'b0110011;
    localparam logic [6:0] C_OP_I   = 7'b0010011;
    localparam logic [6:0] C_OP_LW  = 7'b0000011;
    localparam logic [6:0] C_OP_SW  = 7'b0100011;
    localparam logic [6:0] C_OP_BR  = 7'b1100011;
    localparam logic [6:0] C_OP_JAL = 7'b1101111;
    localparam logic [6:0] C_OP_LUI = 7'b0110111;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADR   = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXEC_R    = 4'd6,
        ST_EXEC_I    = 4'd7,
        ST_EXEC_LUI  = 4'd8,
        ST_ALU_WB    = 4'd9,
        ST_BRANCH    = 4'd10,
        ST_JAL       = 4'd11,
        ST_ILLEGAL   = 4'd12
    } state_t;

    state_t     r_state;
    logic [3:0] w_funct_alu;
    logic       w_known_op;

    assign w_known_op = (opcode == C_OP_R)  || (opcode == C_OP_I)  ||
                        (opcode == C_OP_LW) || (opcode == C_OP_SW) ||
                        (opcode == C_OP_BR) || (opcode == C_OP_JAL) ||
                        (opcode == C_OP_LUI);

    // State register; reset aborts any instruction in flight and returns to FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH:     r_state <= ST_DECODE;
                ST_DECODE: begin
                    if (opcode == C_OP_LW || opcode == C_OP_SW) r_state <= ST_MEM_ADR;
                    else if (opcode == C_OP_R)   r_state <= ST_EXEC_R;
                    else if (opcode == C_OP_I)   r_state <= ST_EXEC_I;
                    else if (opcode == C_OP_LUI) r_state <= ST_EXEC_LUI;
                    else if (opcode == C_OP_BR)  r_state <= ST_BRANCH;
                    else if (opcode == C_OP_JAL) r_state <= ST_JAL;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
                    else                         r_state <= ST_ILLEGAL;
`else
                    else                         r_state <= ST_FETCH;
`endif
                end
                ST_MEM_ADR:   r_state <= (opcode == C_OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
                ST_MEM_READ:  r_state <= ST_MEM_WB;
                ST_MEM_WB:    r_state <= ST_FETCH;
                ST_MEM_WRITE: r_state <= ST_FETCH;
                ST_EXEC_R:    r_state <= ST_ALU_WB;
                ST_EXEC_I:    r_state <= ST_ALU_WB;
                ST_EXEC_LUI:  r_state <= ST_ALU_WB;
                ST_ALU_WB:    r_state <= ST_FETCH;
                ST_BRANCH:    r_state <= ST_FETCH;
                ST_JAL:       r_state <= ST_ALU_WB;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
                ST_ILLEGAL:   r_state <= ST_ILLEGAL;
`endif
                default:      r_state <= ST_FETCH;
            endcase
        end
    end

    // ALU operation from funct3/funct7b5; sub only for R-type so addi ignores bit 30.
    always_comb begin
        w_funct_alu = 4'b0000;
        case (funct3)
            3'b000:  w_funct_alu = (opcode == C_OP_R && funct7b5) ? 4'b0001 : 4'b0000;
            3'b001:  w_funct_alu = 4'b0110;
            3'b010:  w_funct_alu = 4'b0101;
            3'b011:  w_funct_alu = 4'b1001;
            3'b100:  w_funct_alu = 4'b0100;
            3'b101:  w_funct_alu = funct7b5 ? 4'b1000 : 4'b0111;
            3'b110:  w_funct_alu = 4'b0011;
            default: w_funct_alu = 4'b0010;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        imm_src = 3'b000;
        case (opcode)
            C_OP_SW:  imm_src = 3'b001;
            C_OP_BR:  imm_src = 3'b010;
            C_OP_JAL: imm_src = 3'b011;
            C_OP_LUI: imm_src = 3'b100;
            default:  imm_src = 3'b000;
        endcase
    end

    // Per-state control outputs; anything not set stays 0.
    always_comb begin
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_control   = 4'b0000;
        instr_retired = 1'b0;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
        illegal_instr = 1'b0;
`endif
        case (r_state)
            ST_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            ST_DECODE: begin
                // Precompute OldPC + imm so the branch/jump target sits in ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
`ifndef RISCV_CTRL_ILLEGAL_TRAP_EN
                instr_retired = !w_known_op;
`endif
            end
            ST_MEM_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            ST_MEM_READ: begin
                adr_src = 1'b1;
            end
            ST_MEM_WB: begin
                result_src    = 2'b01;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            ST_MEM_WRITE: begin
                adr_src       = 1'b1;
                mem_write     = 1'b1;
                instr_retired = 1'b1;
            end
            ST_EXEC_R: begin
                alu_src_a   = 2'b10;
                alu_control = w_funct_alu;
            end
            ST_EXEC_I: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = w_funct_alu;
            end
            ST_EXEC_LUI: begin
                alu_src_b   = 2'b01;
                alu_control = 4'b1010;
            end
            ST_ALU_WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            ST_BRANCH: begin
                // funct3[0] inverts the sense: beq takes on zero, bne on not-zero.
                alu_src_a     = 2'b10;
                alu_control   = 4'b0001;
                pc_write      = zero ^ funct3[0];
                instr_retired = 1'b1;
            end
            ST_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
            ST_ILLEGAL: begin
                illegal_instr = 1'b1;
            end
`endif
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_mc_control_unit
// Brief    : Scoreboard bench for riscv_mc_control_unit. Stimulus pushes the
//            expected control word for each upcoming cycle; a monitor pops and
//            compares on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mc_control_unit;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_retired;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       ill;

    riscv_mc_control_unit dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_src       (imm_src),
        .alu_control   (alu_control),
        .instr_retired (instr_retired)
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_instr (ill)
`endif
    );

`ifndef RISCV_CTRL_ILLEGAL_TRAP_EN
    assign ill = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [19:0] word;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Control word: {pcw, adr, memw, irw, regw, result_src, src_a, src_b, imm_src, alu, retired, illegal}
    function automatic logic [19:0] cw(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] imm, input logic [3:0] alu,
                                       input logic ret, input logic il);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ret, il};
    endfunction

    function automatic logic [19:0] fetch_w(input logic [2:0] imm);
        return cw(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 4'b0000, 0, 0);
    endfunction

    function automatic logic [19:0] decode_w(input logic [2:0] imm, input logic ret);
        return cw(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 4'b0000, ret, 0);
    endfunction

    function automatic logic [19:0] aluwb_w(input logic [2:0] imm);
        return cw(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 4'b0000, 1, 0);
    endfunction

    task automatic push(input string n, input logic [19:0] w);
        exp_t e;
        e.name = n;
        e.word = w;
        q.push_back(e);
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        opcode   = op;
        funct3   = f3;
        funct7b5 = f7;
        zero     = z;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Four-cycle ALU-type instruction: FETCH, DECODE, EXEC, ALU_WB.
    task automatic run_alu(input string n, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input logic [2:0] imm,
                           input logic [19:0] exec_w);
        set_in(op, f3, f7, z);
        push({n, "/fetch"},  fetch_w(imm));
        push({n, "/decode"}, decode_w(imm, 0));
        push({n, "/exec"},   exec_w);
        push({n, "/wb"},     aluwb_w(imm));
        cycles(4);
    endtask

    task automatic run_branch(input string n, input logic [2:0] f3, input logic z, input logic take);
        set_in(7'b1100011, f3, 1'b0, z);
        push({n, "/fetch"},  fetch_w(3'b010));
        push({n, "/decode"}, decode_w(3'b010, 0));
        push({n, "/branch"}, cw(take, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 4'b0001, 1, 0));
        cycles(3);
    endtask

    // Monitor: every falling edge with a pending expectation is compared.
    always @(negedge clk) begin
        logic [19:0] act;
        exp_t        e;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                   alu_src_a, alu_src_b, imm_src, alu_control, instr_retired, ill};
            n_checks++;
            if (act !== e.word) begin
                n_errors++;
                $display("FAIL %s: got %b required %b", e.name, act, e.word);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    initial begin
        reset = 1'b0;
        set_in(OP_R, 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        push("reset_hold0", fetch_w(3'b000));
        push("reset_hold1", fetch_w(3'b000));
        cycles(2);
        reset = 1'b1;

        // R/I ALU instructions with hand-decoded alu_control
        run_alu("add",  OP_R, 3'b000, 0, 1, 3'b000, cw(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0000,0,0));
        run_alu("sub",  OP_R, 3'b000, 1, 0, 3'b000, cw(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0,0));
        run_alu("addi_f7", OP_I, 3'b000, 1, 0, 3'b000, cw(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b0000,0,0));
        run_alu("srai", OP_I, 3'b101, 1, 0, 3'b000, cw(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b1000,0,0));
        run_alu("srl",  OP_R, 3'b101, 0, 0, 3'b000, cw(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0111,0,0));
        run_alu("or",   OP_R, 3'b110, 0, 0, 3'b000, cw(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0011,0,0));
        run_alu("and",  OP_R, 3'b111, 0, 0, 3'b000, cw(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0010,0,0));
        run_alu("sltu", OP_R, 3'b011, 0, 0, 3'b000, cw(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b1001,0,0));
        run_alu("xori", OP_I, 3'b100, 0, 0, 3'b000, cw(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b0100,0,0));
        run_alu("slti", OP_I, 3'b010, 0, 0, 3'b000, cw(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b0101,0,0));
        run_alu("slli", OP_I, 3'b001, 0, 0, 3'b000, cw(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b0110,0,0));
        run_alu("lui",  7'b0110111, 3'b000, 0, 0, 3'b100, cw(0,0,0,0,0,2'b00,2'b00,2'b01,3'b100,4'b1010,0,0));

        // jal: FETCH, DECODE, JAL, ALU_WB
        set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
        push("jal/fetch",  fetch_w(3'b011));
        push("jal/decode", decode_w(3'b011, 0));
        push("jal/jal",    cw(1,0,0,0,0,2'b00,2'b01,2'b10,3'b011,4'b0000,0,0));
        push("jal/wb",     aluwb_w(3'b011));
        cycles(4);

        // lw: five cycles
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
        push("lw/fetch",   fetch_w(3'b000));
        push("lw/decode",  decode_w(3'b000, 0));
        push("lw/memadr",  cw(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b0000,0,0));
        push("lw/memread", cw(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,0,0));
        push("lw/memwb",   cw(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,4'b0000,1,0));
        cycles(5);

        // sw: four cycles, single mem_write strobe
        set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
        push("sw/fetch",    fetch_w(3'b001));
        push("sw/decode",   decode_w(3'b001, 0));
        push("sw/memadr",   cw(0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,4'b0000,0,0));
        push("sw/memwrite", cw(0,1,1,0,0,2'b00,2'b00,2'b00,3'b001,4'b0000,1,0));
        cycles(4);

        run_branch("beq_z1", 3'b000, 1'b1, 1'b1);
        run_branch("beq_z0", 3'b000, 1'b0, 1'b0);
        run_branch("bne_z0", 3'b001, 1'b0, 1'b1);
        run_branch("bne_z1", 3'b001, 1'b1, 1'b0);

        // Reset asserted in ALU_WB must suppress reg_write before the next clock edge
        set_in(OP_R, 3'b000, 1'b0, 1'b0);
        push("abort/fetch",  fetch_w(3'b000));
        push("abort/decode", decode_w(3'b000, 0));
        push("abort/exec",   cw(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0000,0,0));
        cycles(3);
        #1 reset = 1'b0;
        push("abort/async_reset", fetch_w(3'b000));
        cycles(1);
        push("abort/reset_held", fetch_w(3'b000));
        cycles(1);
        reset = 1'b1;

        // Unknown opcode
        set_in(7'b1111111, 3'b000, 1'b0, 1'b0);
        push("unk/fetch", fetch_w(3'b000));
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
        push("unk/decode", decode_w(3'b000, 0));
        push("unk/illegal0", cw(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,0,1));
        push("unk/illegal1", cw(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,0,1));
        push("unk/illegal2", cw(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,0,1));
        cycles(5);
        reset = 1'b0;
        push("unk/reset", fetch_w(3'b000));
        cycles(1);
        reset = 1'b1;
`else
        push("unk/decode_nop", decode_w(3'b000, 1));
        cycles(2);
`endif
        run_alu("add_after", OP_R, 3'b000, 0, 0, 3'b000, cw(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0000,0,0));

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_mc_control_unit.md
# riscv_mc_control_unit

Multicycle control FSM for the RV32I core. It decodes the instruction register fields and sequences the datapath enables and mux selects: PC register, address mux, instruction/data memory, OldPC/instruction registers, register file, SrcA/SrcB muxes and ALU. It sits directly upstream of the datapath and drives every control net the datapath leaves tied off. It is purely a control block; no data values pass through it.

## Interface
- No parameters; all encodings below are fixed.
- `clk`  in  1  core clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `opcode`  in  7  Instruction_w[6:0]
- `funct3`  in  3  Instruction_w[14:12]
- `funct7b5`  in  1  Instruction_w[30]
- `zero`  in  1  ALU zero flag
- `pc_write`  out  1  PC register enable
- `adr_src`  out  1  0 = PC, 1 = Result
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  instruction/OldPC register enable
- `reg_write`  out  1  register file write
- `result_src`  out  2  00 ALUOut, 01 Data reg, 10 ALU result
- `alu_src_a`  out  2  00 PC, 01 OldPC, 10 rs1 reg
- `alu_src_b`  out  2  00 rs2 reg, 01 ImmExt, 10 constant 4
- `imm_src`  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- `alu_control`  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu, 1010 passB
- `instr_retired`  out  1  one-cycle pulse in the final state of each instruction

## Operation
- States: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, EXEC_LUI, ALU_WB, BRANCH, JAL, plus ILLEGAL under the macro.
- Opcodes:
  - R = 0110011
  - I = 0010011
  - LW = 0000011
  - SW = 0100011
  - BR = 1100011
  - JAL = 1101111
  - LUI = 0110111
- FETCH: adr_src=0, ir_write=1, src_a=00, src_b=10, add, result_src=10, pc_write=1. Always goes to DECODE.
- DECODE: src_a=01, src_b=01, add. This leaves the branch/jump target in ALUOut. Next state by opcode:
  - LW/SW → MEM_ADR
  - R → EXEC_R
  - I → EXEC_I
  - LUI → EXEC_LUI
  - BR → BRANCH
  - JAL → JAL
  - otherwise → see Configuration
- MEM_ADR: src_a=10, src_b=01, add. LW → MEM_READ; SW → MEM_WRITE.
- MEM_READ: result_src=00, adr_src=1, then MEM_WB.
- MEM_WB: result_src=01, reg_write=1, retire, then FETCH.
- MEM_WRITE: result_src=00, adr_src=1, mem_write=1, retire, then FETCH.
- EXEC_R: src_a=10, src_b=00, funct decode, then ALU_WB.
- EXEC_I: src_a=10, src_b=01, funct decode, then ALU_WB.
- EXEC_LUI: src_b=01, passB, then ALU_WB.
- ALU_WB: result_src=00, reg_write=1, retire, then FETCH.
- BRANCH: src_a=10, src_b=00, sub, result_src=00. pc_write = zero XOR funct3[0] (covers beq and bne). Retire, then FETCH.
- JAL: src_a=01, src_b=10, add, result_src=00, pc_write=1, then ALU_WB (writes OldPC+4 to rd).
- Funct decode, keyed on funct3:
  - 000: sub only when R-type and funct7b5=1; add otherwise
  - 001: sll
  - 010: slt
  - 011: sltu
  - 100: xor
  - 101: sra if funct7b5=1, else srl
  - 110: or
  - 111: and
- imm_src is combinational from opcode: SW→001, BR→010, JAL→011, LUI→100, all others→000.
- Outputs not listed for a state are 0 (selects default to 00).

## Timing
- State register updates on the rising clk edge. All outputs are combinational from state, opcode, funct fields and zero.
- Reset low forces FETCH asynchronously; instr_retired=0 during reset.
- While in reset, outputs take the FETCH values. The datapath registers are held in reset at the same time, so these values are harmless.
- First fetch occurs on the first rising edge after reset deasserts.
- Cycles per instruction, FETCH through retire:
  - lw 5
  - sw 4
  - R/I/LUI/JAL 4
  - branch 3
- Reset asserted mid-instruction aborts it. No partial mem_write or reg_write may occur after the reset edge.
- zero is sampled only in BRANCH.

## Configuration
- `RISCV_CTRL_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE goes to ILLEGAL.
  - ILLEGAL asserts output `illegal_instr`=1 and all other enables 0.
  - The FSM stays in ILLEGAL until reset.
- Undefined: an unknown opcode goes DECODE → FETCH as a NOP.
  - instr_retired pulses in the DECODE cycle.
  - No `illegal_instr` port exists.

## Test plan
- Reset low mid-cycle → state FETCH immediately. On release: ir_write=1, pc_write=1, src_b=10.
- add x3,x1,x2 (R, funct7b5=0) → FETCH, DECODE, EXEC_R, ALU_WB. alu_control=0000, reg_write=1 only in cycle 4, instr_retired pulse in cycle 4.
- lw opcode → 5-cycle sequence. adr_src=1 in MEM_READ; result_src=01 with reg_write=1 in MEM_WB.
- sw opcode → mem_write=1 exactly one cycle, in cycle 4; reg_write never 1.
- Branch cases:
  - beq with zero=1 → pc_write=1 in cycle 3
  - beq with zero=0 → pc_write=0
  - bne (funct3=001) with zero=0 → pc_write=1
- opcode 1111111 with the macro defined → illegal_instr=1 and stuck until reset. Without the macro → back to FETCH after DECODE.
